// File: rtl/input_arb_pkg.sv
// input_arb_pkg: shared types and helpers for the controller input arbiter
package input_arb_pkg;

    typedef enum logic [1:0] {
        SRC_SNES = 2'd0,
        SRC_IR   = 2'd1,
        SRC_PS2  = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        FIXED,
        IDLE,
        OWNED
    } arb_state_e;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef logic [3:0] dir_t;

    // Drops both halves of any opposing pair so game logic never sees Up+Down or Left+Right
    function automatic dir_t resolve_dir(dir_t d);
        dir_t r;
        r = d;
        if (d[DIR_UP] && d[DIR_DOWN]) begin
            r[DIR_UP]   = 1'b0;
            r[DIR_DOWN] = 1'b0;
        end
        if (d[DIR_LEFT] && d[DIR_RIGHT]) begin
            r[DIR_LEFT]  = 1'b0;
            r[DIR_RIGHT] = 1'b0;
        end
        return r;
    endfunction

    // Round-robin successor over the three real sources
    function automatic src_e next_src(src_e s);
        return s == SRC_SNES ? SRC_IR : s == SRC_IR ? SRC_PS2 : SRC_SNES;
    endfunction

endpackage

// File: rtl/dir_rate_limiter.sv
// dir_rate_limiter: conflict masking and hold-repeat throttling of the owner's direction samples
module dir_rate_limiter
    import input_arb_pkg::*;
#(
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       valid_i,
    input  logic [3:0] dir_i,
    output logic [3:0] pulse_o
);

    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RPT_LOAD = RW'(REPEAT_CYCLES - 1);

    dir_t          res;
    dir_t          last_q, last_d;
    dir_t          pulse_q, pulse_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          fire;

    // A new direction fires at once; an unchanged one only once the repeat window has expired
    always_comb begin
        res     = resolve_dir(dir_i);
        fire    = valid_i && !clear_i && res != 4'd0 && (res != last_q || rpt_q == '0);
        last_d  = clear_i ? 4'd0 : valid_i ? res : last_q;
        rpt_d   = clear_i ? '0 : fire ? RPT_LOAD : rpt_q != '0 ? rpt_q - RW'(1) : '0;
        pulse_d = fire ? res : 4'd0;
    end

    // Pulse, last-emitted direction and repeat counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= 4'd0;
            rpt_q   <= '0;
            pulse_q <= 4'd0;
        end else begin
            last_q  <= last_d;
            rpt_q   <= rpt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/input_arbiter.sv
// input_arbiter: picks one controller front-end as direction owner (fixed or first-activity);
// define INPUT_ARB_ROTATE_EN to break simultaneous claims round-robin instead of SNES > IR > PS2
module input_arbiter
    import input_arb_pkg::*;
#(
    parameter int IDLE_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [1:0] Choice,
    input  logic [3:0] NDir,
    input  logic [3:0] IDir,
    input  logic [3:0] PDir,
    input  logic       NReadable,
    input  logic       IReadable,
    input  logic       PReadable,
    output logic       Up,
    output logic       Down,
    output logic       Left,
    output logic       Right,
    output logic [1:0] Owner
);

    localparam int IW = $clog2(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_CYCLES - 1);

    arb_state_e    state_q, state_d;
    src_e          owner_q, owner_d;
    src_e          win, src;
    logic [1:0]    choice_q;
    logic [IW-1:0] idle_q, idle_d;
    logic [3:0]    act, rdy;
    logic          changed, smp_valid;
    dir_t          smp_dir, pulse;
`ifdef INPUT_ARB_ROTATE_EN
    src_e          last_q, last_d, r0, r1, r2;
`endif

    assign act = {1'b0, PReadable && PDir != 4'd0, IReadable && IDir != 4'd0, NReadable && NDir != 4'd0};
    assign rdy = {1'b0, PReadable, IReadable, NReadable};

`ifdef INPUT_ARB_ROTATE_EN
    // Search starts just after the most recent owner
    always_comb begin
        r0  = next_src(last_q);
        r1  = next_src(r0);
        r2  = next_src(r1);
        win = act[r0] ? r0 : act[r1] ? r1 : act[r2] ? r2 : SRC_NONE;
    end
`else
    // Fixed claim priority SNES > IR > PS2
    always_comb win = act[SRC_SNES] ? SRC_SNES : act[SRC_IR] ? SRC_IR : act[SRC_PS2] ? SRC_PS2 : SRC_NONE;
`endif

    assign changed   = Choice != choice_q;
    assign src       = state_q == IDLE ? win : owner_q;
    assign smp_valid = rdy[src];
    assign smp_dir   = src == SRC_SNES ? NDir : src == SRC_IR ? IDir : PDir;

    // Ownership FSM: a Choice change overrides everything, then claim, then idle timeout
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        idle_d  = idle_q;
`ifdef INPUT_ARB_ROTATE_EN
        last_d  = last_q;
`endif
        if (changed) begin
            state_d = Choice == 2'b11 ? IDLE : FIXED;
            owner_d = src_e'(Choice);
            idle_d  = '0;
        end else if (state_q == IDLE && win != SRC_NONE) begin
            state_d = OWNED;
            owner_d = win;
            idle_d  = IDLE_LOAD;
`ifdef INPUT_ARB_ROTATE_EN
            last_d  = win;
`endif
        end else if (state_q == OWNED) begin
            if (act[owner_q]) begin
                idle_d = IDLE_LOAD;
            end else if (idle_q == '0) begin
                state_d = IDLE;
                owner_d = SRC_NONE;
            end else begin
                idle_d = idle_q - IW'(1);
            end
        end
    end

    // Arbiter state registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            owner_q  <= SRC_NONE;
            idle_q   <= '0;
            choice_q <= 2'b11;
`ifdef INPUT_ARB_ROTATE_EN
            last_q   <= SRC_PS2;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            idle_q   <= idle_d;
            choice_q <= Choice;
`ifdef INPUT_ARB_ROTATE_EN
            last_q   <= last_d;
`endif
        end
    end

    dir_rate_limiter #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_rate (
        .clk_i  (Clock),
        .rst_ni (Reset_n),
        .clear_i(changed),
        .valid_i(smp_valid),
        .dir_i  (smp_dir),
        .pulse_o(pulse)
    );

    assign Up    = pulse[DIR_UP];
    assign Down  = pulse[DIR_DOWN];
    assign Left  = pulse[DIR_LEFT];
    assign Right = pulse[DIR_RIGHT];
    assign Owner = owner_q;

endmodule

// File: doc/input_arbiter.md
# input_arbiter

Shares the single direction path into game logic among the three controller front-ends (SNES/NES, IR, PS2). Selects an owning source either fixed by `Choice` or automatically by first activity, strips contradictory directions, and rate-limits held directions into one-cycle move pulses. Sits between the controller decoders and game logic inside the player block, replacing the purely combinational select.

## Interface
- `IDLE_CYCLES`, 25_000_000: auto-mode ownership timeout in clocks (0.5 s at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, 5_000_000: minimum clocks between repeated pulses of an unchanged direction; must be ≥ 1.

- `Clock`  in  1  system clock, all logic on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Choice`  in  2  00 SNES, 01 IR, 10 PS2, 11 auto-select.
- `NDir`, `IDir`, `PDir`  in  4 each  {Up, Down, Left, Right} from each front-end.
- `NReadable`, `IReadable`, `PReadable`  in  1 each  one-cycle strobe: matching `*Dir` is valid.
- `Up`, `Down`, `Left`, `Right`  out  1 each  registered one-cycle move pulses.
- `Owner`  out  2  current owner encoding as `Choice`; 11 = none.

## Operation
- Source "active" on a cycle = its `Readable` high and `Dir` ≠ 0; `Dir` ignored when `Readable` low.
- Conflict mask: Up&Down both set → both dropped; Left&Right both set → both dropped. Masked value = resolved dir; resolved 0 produces no pulse but still counts as activity.
- States: `FIXED`, `IDLE`, `OWNED`.
  - `Choice` ≠ 11 → `FIXED`, `Owner` = `Choice`; non-selected sources ignored.
  - `Choice` = 11, in `IDLE`: first active source claims → `OWNED`, `Owner` = claimant, idle counter loaded with `IDLE_CYCLES`-1; the claiming sample is also processed for emission.
  - `OWNED`: owner activity reloads idle counter; otherwise decrement; at 0 → `IDLE`, `Owner` = 11. Non-owner activity ignored.
  - Any `Choice` change: next cycle enters `FIXED` (new value) or `IDLE` (11); last-emitted dir and repeat counter cleared.
- Simultaneous claims in `IDLE`: fixed priority SNES > IR > PS2 (see Configuration).
- Emission (owner sample, resolved dir R ≠ 0): if R ≠ last-emitted dir, or repeat counter = 0 → pulse R, store R as last-emitted, load repeat counter with `REPEAT_CYCLES`-1. Else suppress.
- Repeat counter decrements to 0 and holds. Owner sample with R = 0 clears last-emitted dir.
- Counter widths: `$clog2(param)`; no wrap — counters saturate at 0.

## Timing
- Reset values: all pulse outputs 0, `Owner` 11, state `IDLE`, counters 0, last-emitted 0. After release with `Choice` ≠ 11, `Owner` = `Choice` on the first clock.
- Latency: strobe at edge t → pulse visible after edge t+1, high exactly one cycle.
- Ownership timeout: last owner strobe at edge t → `Owner` = 11 after edge t+`IDLE_CYCLES`; a strobe on that same edge wins (reload, stays `OWNED`).
- Repeat: same dir strobed every cycle → pulses exactly every `REPEAT_CYCLES` cycles.
- Claim and timeout on same cycle by a non-owner: timeout first; the claim is taken on the next active strobe, not retroactively.
- `Reset_n` low mid-operation: immediate return to reset values, pending pulse dropped.

## Configuration
- `INPUT_ARB_ROTATE_EN` defined: simultaneous claims in `IDLE` resolved round-robin, starting after the most recent owner (reset pointer: SNES highest).
- Undefined: fixed priority SNES > IR > PS2. No other behaviour differs.

## Structure
- Package `input_arb_pkg`: `src_e` (SRC_SNES=0, SRC_IR=1, SRC_PS2=2, SRC_NONE=3), `arb_state_e` (FIXED, IDLE, OWNED), direction bit index constants (DIR_UP=3 … DIR_RIGHT=0), `dir_t` 4-bit typedef.
- Sub-module `dir_rate_limiter`: conflict mask, last-emitted register, repeat counter, pulse register; top holds FSM, owner mux, idle counter, priority/rotation.

## Test plan
- Reset, `Choice`=01, IDir=1000 strobed once → `Owner`=01 after first clock; `Up` pulse 1 cycle after strobe; NDir strobes ignored.
- `Choice`=11, NReadable and PReadable same cycle (dirs 0010, 0001) → `Owner`=00, `Left` pulse only; with `INPUT_ARB_ROTATE_EN` and prior owner SNES → `Owner`=10, `Right`.
- `REPEAT_CYCLES`=4, owner strobes 0100 every cycle for 12 cycles → `Down` pulses at cycles 1, 5, 9; switch to 0010 on cycle 6 → immediate `Left` pulse.
- Strobe 1100 then 0011 → no pulses, activity still reloads idle counter.
- `IDLE_CYCLES`=8, owner IR strobes once, silence → `Owner`=11 exactly 8 clocks later; then PS2 strobe 1000 → `Owner`=10, `Up` pulse.
- Assert `Reset_n` low one cycle after a strobe → no pulse, `Owner`=11, counters zero.
